// File: rtl/pixel_streamer_if.sv
// Handshake bundle between the image loader, the pixel streamer
// and the convolution front end.
interface pixel_streamer_if #(
    parameter int DATA_BIT = 8,
    parameter int ADDR_BIT = 10
) ();
    logic                wr_en;
    logic [ADDR_BIT-1:0] wr_addr;
    logic [DATA_BIT-1:0] wr_data;
    logic                wr_ready;
    logic                start;
    logic                busy;
    logic [DATA_BIT-1:0] out_data;
    logic                out_valid;
    logic                frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  wr_ready, busy, out_data, out_valid, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output wr_ready, busy, out_data, out_valid, frame_done
    );
endinterface

// File: rtl/pixel_streamer.sv
// Frame buffer that replays one image in raster order, one pixel
// per clock, followed by a run of zero flush cycles.
module pixel_streamer #(
    parameter int WIDTH        = 28,
    parameter int HEIGHT       = 28,
    parameter int DATA_BIT     = 8,
    parameter int ADDR_BIT     = 10,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    pixel_streamer_if.slave bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int FB   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [ADDR_BIT-1:0] LAST = ADDR_BIT'(NPIX - 1);
    localparam logic [FB-1:0] FLAST =
        FB'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_BIT-1:0] cnt_q, cnt_d;
    logic [FB-1:0]       fcnt_q, fcnt_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, done_q, ready_q;
    logic [DATA_BIT-1:0] mem [NPIX];
    logic                accept;
    logic                wr_hit;

    // The cycle after DONE still shows frame_done, so it is not yet open.
    assign accept = (state_q == IDLE) && ready_q;
    assign wr_hit = accept && bus.wr_en && (bus.wr_addr <= LAST);

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        data_d  = '0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                fcnt_d = '0;
                if (accept && bus.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                data_d  = mem[cnt_q];
                valid_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == FLAST) begin
                    fcnt_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == DONE);
            ready_q <= (state_d == IDLE) && (state_q != DONE);
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.wr_ready   = ready_q;
endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench: a default streamer (8 flush cycles) and a
// zero-flush streamer share the write port and replay frames.
module tb_pixel_streamer;
    localparam int NPIX = 28 * 28;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] model [NPIX];
    logic [7:0] exp_q [$];

    pixel_streamer_if #(.DATA_BIT(8), .ADDR_BIT(10)) ifa ();
    pixel_streamer_if #(.DATA_BIT(8), .ADDR_BIT(10)) ifb ();

    pixel_streamer #(.FLUSH_CYCLES(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    pixel_streamer #(.FLUSH_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic wr_both(input logic [9:0] a, input logic [7:0] v);
        ifa.wr_en = 1'b1; ifa.wr_addr = a; ifa.wr_data = v;
        ifb.wr_en = 1'b1; ifb.wr_addr = a; ifb.wr_data = v;
        if (a < 10'(NPIX)) model[a] = v;
        @(posedge clk); #1;
        ifa.wr_en = 1'b0;
        ifb.wr_en = 1'b0;
    endtask

    task automatic run_frame(input bit d, input int abort_at,
                             input int poke_at, input bit wr_start);
        int f;
        logic v, fd, bz, rdy;
        logic [7:0] od;
        f = d ? 0 : 8;
        if (wr_start) begin
            ifa.wr_en = 1'b1; ifa.wr_addr = '0; ifa.wr_data = 8'hAA;
            ifb.wr_en = 1'b1; ifb.wr_addr = '0; ifb.wr_data = 8'hAA;
            model[0] = 8'hAA;
        end
        for (int i = 0; i < NPIX; i++) exp_q.push_back(model[i]);
        if (d) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(posedge clk); #1;
        ifa.start = 1'b0; ifb.start = 1'b0;
        ifa.wr_en = 1'b0; ifb.wr_en = 1'b0;
        bz  = d ? ifb.busy : ifa.busy;
        rdy = d ? ifb.wr_ready : ifa.wr_ready;
        v   = d ? ifb.out_valid : ifa.out_valid;
        chk("busy_at_start", bz, 1);
        chk("ready_at_start", rdy, 0);
        chk("valid_at_start", v, 0);
        for (int t = 1; t <= NPIX + f + 2; t++) begin
            @(posedge clk); #1;
            ifa.start = 1'b0;
            ifa.wr_en = 1'b0;
            v   = d ? ifb.out_valid : ifa.out_valid;
            od  = d ? ifb.out_data : ifa.out_data;
            fd  = d ? ifb.frame_done : ifa.frame_done;
            bz  = d ? ifb.busy : ifa.busy;
            rdy = d ? ifb.wr_ready : ifa.wr_ready;
            chk("valid", v, 32'(t <= NPIX));
            chk("frame_done", fd, 32'(t == NPIX + f + 1));
            chk("busy", bz, 32'(t <= NPIX + f));
            chk("wr_ready", rdy, 32'(t >= NPIX + f + 2));
            if (v) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else chk("pixel", od, exp_q.pop_front());
            end else begin
                chk("idle_data", od, 0);
            end
            if (t == poke_at) begin
                ifa.start   = 1'b1;
                ifa.wr_en   = 1'b1;
                ifa.wr_addr = 10'd5;
                ifa.wr_data = 8'hFF;
            end
            if (t == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_data", ifa.out_data, 0);
                chk("abort_valid", ifa.out_valid, 0);
                chk("abort_busy", ifa.busy, 0);
                chk("abort_done", ifa.frame_done, 0);
                chk("abort_ready", ifa.wr_ready, 1);
                #1 rst = 1'b1;
                exp_q.delete();
                repeat (20) begin
                    @(posedge clk); #1;
                    chk("no_done_after_abort", ifa.frame_done, 0);
                end
                return;
            end
        end
        chk("sb_leftover", exp_q.size(), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.start = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifb.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_data", ifa.out_data, 0);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.frame_done, 0);
        chk("rst_ready", ifa.wr_ready, 1);
        chk("rst_ready_b", ifb.wr_ready, 1);

        for (int i = 0; i < NPIX; i++) wr_both(10'(i), 8'(i));
        run_frame(0, 0, 0, 0);

        wr_both(10'd784, 8'h11);
        wr_both(10'd1023, 8'h22);
        run_frame(0, 0, 0, 0);

        run_frame(0, 0, 100, 0);
        run_frame(0, 0, 0, 0);

        run_frame(0, 400, 0, 0);
        run_frame(0, 0, 0, 0);

        run_frame(0, 0, 0, 1);

        run_frame(1, 0, 0, 0);
        run_frame(1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
